// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the DIGIT/WIDTH legality rule used at elaboration.
package serial_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // DIGIT must be a positive divisor of WIDTH so every step consumes a full digit.
    function automatic bit digit_legal(input int width, input int digit);
        return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout set when the bit underflows.
module fullsub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: Diff = A - B - Bin, DIGIT bits per clock,
// LSB first, borrow carried between steps in a register.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    generate
        if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_param
            $error("serial_subtractor: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic [DIGIT-1:0] w_dbits;
    logic [DIGIT:0]   w_bchain;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;
    logic             w_last;

    // Borrow ripples through DIGIT full subtractors within one clock.
    assign w_bchain[0] = r_borrow;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_chain
            fullsub u_fullsub (
                .A    (r_a[gi]),
                .B    (r_b[gi]),
                .Bin  (w_bchain[gi]),
                .Diff (w_dbits[gi]),
                .Bout (w_bchain[gi+1])
            );
        end

        // A full-width digit leaves nothing to shift; the slices below would be empty.
        if (DIGIT == WIDTH) begin : g_single
            assign w_a_shift  = '0;
            assign w_b_shift  = '0;
            assign w_res_next = w_dbits;
        end else begin : g_multi
            assign w_a_shift  = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shift  = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_res_next = {w_dbits, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_count == CW'(N - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a      <= A;
                r_b      <= B;
                r_borrow <= Bin;
                r_count  <= '0;
            end else if (r_state == RUN) begin
                r_a      <= w_a_shift;
                r_b      <= w_b_shift;
                r_res    <= w_res_next;
                r_borrow <= w_bchain[DIGIT];
                r_count  <= r_count + CW'(1);
                // Visible result only moves on the final step.
                if (w_last) begin
                    r_diff <= w_res_next;
                    r_bout <= w_bchain[DIGIT];
                end
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = r_done;
    assign Diff   = r_diff;
    assign Borrow = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench: three WIDTH=8 instances (DIGIT 1, 4, 8)
// compared against an integer-arithmetic reference.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] bor_v;
    logic [7:0] diff_v [3];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_diff [3];
    int exp_bor  [3];
    int lat      [3] = '{8, 2, 1};

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(A), .B(B), .Bin(Bin),
        .busy(busy_v[0]), .done(done_v[0]), .Diff(diff_v[0]), .Borrow(bor_v[0])
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(A), .B(B), .Bin(Bin),
        .busy(busy_v[1]), .done(done_v[1]), .Diff(diff_v[1]), .Borrow(bor_v[1])
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(A), .B(B), .Bin(Bin),
        .busy(busy_v[2]), .done(done_v[2]), .Diff(diff_v[2]), .Borrow(bor_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: plain integer subtraction, borrow when the true result is negative.
    task automatic ref_sub(input int a, input int b, input int bin, output int d, output int bo);
        int t;
        t  = a - b - bin;
        bo = (t < 0) ? 1 : 0;
        d  = t & 255;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_diff[i] = 0;
            exp_bor[i]  = 0;
        end
    endtask

    // Issue one operation on instance sel and check latency, hold and result.
    task automatic do_op(input int sel, input int a, input int b, input int bin);
        int cnt;
        int d;
        int bo;
        ref_sub(a, b, bin, d, bo);
        @(negedge clk);
        A = 8'(a); B = 8'(b); Bin = bin[0];
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check($sformatf("busy_after_accept[%0d]", sel), 32'(busy_v[sel]), 32'd1);
        cnt = 0;
        while (!done_v[sel] && cnt < 40) begin
            @(negedge clk);
            cnt++;
            A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
            if (cnt == 1 && lat[sel] > 1)
                check($sformatf("diff_hold[%0d]", sel), 32'(diff_v[sel]), 32'(exp_diff[sel]));
        end
        check($sformatf("latency[%0d]", sel), 32'(cnt), 32'(lat[sel]));
        check($sformatf("diff[%0d]", sel), 32'(diff_v[sel]), 32'(d));
        check($sformatf("borrow[%0d]", sel), 32'(bor_v[sel]), 32'(bo));
        check($sformatf("busy_at_done[%0d]", sel), 32'(busy_v[sel]), 32'd0);
        exp_diff[sel] = d;
        exp_bor[sel]  = bo;
        @(negedge clk);
        check($sformatf("done_one_cycle[%0d]", sel), 32'(done_v[sel]), 32'd0);
        $display("op dut%0d: %0d - %0d - %0d -> diff=%0d borrow=%0d lat=%0d",
                 sel, a, b, bin, diff_v[sel], bor_v[sel], cnt);
    endtask

    initial begin
        int cnt;
        int ndone;
        int pulses [3];
        int np;

        rst_n = 1'b0; start_v = '0; A = '0; B = '0; Bin = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_diff[%0d]", i), 32'(diff_v[i]), 32'd0);
            check($sformatf("rst_borrow[%0d]", i), 32'(bor_v[i]), 32'd0);
        end
        rst_n = 1'b1;

        do_op(0, 200, 55, 0);
        do_op(0, 5, 10, 0);
        do_op(0, 0, 0, 1);
        do_op(0, 8'hA5, 8'hA5, 0);
        do_op(1, 8'h30, 8'h01, 0);
        do_op(2, 8'h30, 8'h01, 0);
        do_op(0, 255, 255, 1);
        do_op(1, 0, 255, 1);
        do_op(2, 255, 0, 1);

        for (int i = 0; i < 24; i++)
            do_op(i % 3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));

        // Second start during a busy operation must be ignored.
        @(negedge clk);
        A = 8'd100; B = 8'd30; Bin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 0; ndone = 0;
        repeat (2) begin @(negedge clk); cnt++; end
        A = 8'd7; B = 8'd99; Bin = 1'b1; start_v[0] = 1'b1;
        @(negedge clk); cnt++;
        start_v[0] = 1'b0;
        while (!done_v[0] && cnt < 40) begin @(negedge clk); cnt++; end
        check("ignore_latency", 32'(cnt), 32'd8);
        check("ignore_diff", 32'(diff_v[0]), 32'd70);
        check("ignore_borrow", 32'(bor_v[0]), 32'd0);
        exp_diff[0] = 70; exp_bor[0] = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("ignore_no_second_done", 32'(ndone), 32'd0);
        check("ignore_idle", 32'(busy_v[0]), 32'd0);
        $display("ignored-start: diff=%0d extra_dones=%0d", diff_v[0], ndone);

        // Asynchronous reset in the middle of an operation.
        do_op(0, 200, 55, 0);
        @(negedge clk);
        A = 8'd50; B = 8'd20; Bin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_done", 32'(done_v[0]), 32'd0);
        check("arst_diff", 32'(diff_v[0]), 32'd0);
        check("arst_borrow", 32'(bor_v[0]), 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        $display("async-reset mid-op: diff=%0d busy=%0d", diff_v[0], busy_v[0]);
        do_op(0, 77, 13, 1);

        // Back-to-back with start held high.
        @(negedge clk);
        A = 8'd9; B = 8'd3; Bin = 1'b0; start_v[0] = 1'b1;
        np = 0;
        for (int c = 0; c < 60 && np < 3; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                pulses[np] = c;
                check($sformatf("b2b_diff%0d", np), 32'(diff_v[0]), 32'd6);
                $display("b2b pulse %0d at cycle %0d diff=%0d", np, c, diff_v[0]);
                np++;
            end
        end
        start_v[0] = 1'b0;
        check("b2b_pulses", 32'(np), 32'd3);
        if (np == 3) begin
            check("b2b_gap0", 32'(pulses[1] - pulses[0]), 32'd9);
            check("b2b_gap1", 32'(pulses[2] - pulses[1]), 32'd9);
        end
        cnt = 0;
        while ((busy_v[0] || done_v[0]) && cnt < 20) begin @(negedge clk); cnt++; end
        check("b2b_drain", 32'(busy_v[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
